// File: rtl/dec_to_ieee754_if.sv
// Handshake bundle for dec_to_ieee754_seq: operand side and result side.
// master = operand producer / result consumer, slave = the converter.
interface dec_to_ieee754_seq_if #(
    parameter int INT_W  = 32,
    parameter int FRAC_W = 32,
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23
);
    localparam int RW = 1 + EXP_W + MAN_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [INT_W-1:0]  in_int;
    logic [FRAC_W-1:0] in_frac;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_result;
    logic              out_inexact;
    logic              out_overflow;
    logic              out_invalid;

    modport master (
        output in_valid, in_sign, in_int, in_frac, out_ready,
        input  in_ready, out_valid, out_result, out_inexact, out_overflow, out_invalid
    );

    modport slave (
        input  in_valid, in_sign, in_int, in_frac, out_ready,
        output in_ready, out_valid, out_result, out_inexact, out_overflow, out_invalid
    );
endinterface

// File: rtl/dec_to_ieee754_seq.sv
// Multi-cycle converter: sign + integer + decimal fraction (scaled by 10**FRAC_DIGITS)
// into an IEEE-754 style binary float. Fraction bits come from iterative doubling.
// Optional feature macro: DEC2FP_RNE_EN selects round-to-nearest-even; otherwise truncation.
// Fixed latency: accept at edge t, out_valid first high after edge t+FRAC_ITER+3.
module dec_to_ieee754_seq #(
    parameter int INT_W       = 32,
    parameter int FRAC_W      = 32,
    parameter int FRAC_DIGITS = 9,
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int FRAC_ITER   = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    dec_to_ieee754_seq_if.slave bus
);
    localparam int VW     = INT_W + FRAC_ITER;
    localparam int PosW   = $clog2(VW);
    localparam int CntW   = $clog2(FRAC_ITER + 1);
    localparam int RW     = 1 + EXP_W + MAN_W;
    localparam int Bias   = 2 ** (EXP_W - 1) - 1;
    localparam int ExpMax = 2 ** EXP_W - 1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [FRAC_W:0] Scale = (FRAC_W + 1)'(pow10(FRAC_DIGITS));

    typedef enum logic [2:0] {StIdle, StFrac, StNorm, StRound, StDone} state_e;

    state_e                r_state;
    logic                  r_sign;
    logic                  r_bad;
    logic [INT_W-1:0]      r_int;
    logic [FRAC_W:0]       r_rem;
    logic [FRAC_ITER-1:0]  r_fbits;
    logic [CntW-1:0]       r_cnt;
    logic                  r_phase;
    logic [PosW-1:0]       r_pos;
    logic                  r_zero;
    logic [MAN_W-1:0]      r_man;
    logic                  r_guard;
    logic                  r_sticky;
    logic signed [31:0]    r_exp;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [RW-1:0]         r_result;
    logic                  r_inexact;
    logic                  r_overflow;
    logic                  r_invalid;

    logic [FRAC_W:0]       w_rem2;
    logic                  w_bit;
    logic [FRAC_W:0]       w_rem_nxt;
    logic [VW-1:0]         w_v;
    logic [PosW-1:0]       w_pos;
    logic                  w_zero;
    logic [VW-1:0]         w_norm;
    logic                  w_up;
    logic [MAN_W:0]        w_man_inc;
    logic signed [31:0]    w_exp_rnd;

    // One doubling step of the decimal remainder yields the next binary fraction bit.
    always_comb begin
        w_rem2    = r_rem << 1;
        w_bit     = (w_rem2 >= Scale);
        w_rem_nxt = w_bit ? (w_rem2 - Scale) : w_rem2;
    end

    // Leading-one search over {int, fracbits}; highest set bit wins.
    always_comb begin
        w_v    = {r_int, r_fbits};
        w_pos  = '0;
        w_zero = 1'b1;
        for (int i = 0; i < VW; i++) begin
            if (w_v[i]) begin
                w_pos  = PosW'(i);
                w_zero = 1'b0;
            end
        end
        // Left-justify so the leading one lands in the MSB.
        w_norm = w_v << (PosW'(VW - 1) - r_pos);
    end

    // Rounding increment and carry into the exponent.
    always_comb begin
`ifdef DEC2FP_RNE_EN
        w_up = r_guard & (r_sticky | r_man[0]);
`else
        w_up = 1'b0;
`endif
        w_man_inc = {1'b0, r_man} + {{MAN_W{1'b0}}, w_up};
        w_exp_rnd = r_exp + $signed({31'b0, w_man_inc[MAN_W]});
    end

    // Control FSM with registered outputs; NORM spends one cycle locating and one extracting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sign      <= 1'b0;
            r_bad       <= 1'b0;
            r_int       <= '0;
            r_rem       <= '0;
            r_fbits     <= '0;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_pos       <= '0;
            r_zero      <= 1'b0;
            r_man       <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_exp       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_inexact   <= 1'b0;
            r_overflow  <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.in_sign;
                        r_int      <= bus.in_int;
                        r_bad      <= ({1'b0, bus.in_frac} >= Scale);
                        // An invalid fraction still runs FRAC; a zero remainder keeps it tame.
                        r_rem      <= ({1'b0, bus.in_frac} >= Scale) ? '0 : {1'b0, bus.in_frac};
                        r_fbits    <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StFrac;
                    end
                end
                StFrac: begin
                    r_rem   <= w_rem_nxt;
                    r_fbits <= {r_fbits[FRAC_ITER-2:0], w_bit};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CntW'(FRAC_ITER - 1)) begin
                        r_phase <= 1'b0;
                        r_state <= StNorm;
                    end
                end
                StNorm: begin
                    if (!r_phase) begin
                        r_pos   <= w_pos;
                        r_zero  <= w_zero;
                        r_exp   <= $signed(32'(w_pos)) - FRAC_ITER + Bias;
                        r_phase <= 1'b1;
                    end else begin
                        r_man    <= w_norm[VW-2 -: MAN_W];
                        r_guard  <= w_norm[VW-2-MAN_W];
                        r_sticky <= (|w_norm[VW-3-MAN_W:0]) | (r_rem != '0);
                        r_state  <= StRound;
                    end
                end
                StRound: begin
                    r_inexact  <= r_guard | r_sticky;
                    r_overflow <= 1'b0;
                    r_invalid  <= 1'b0;
                    if (r_bad) begin
                        r_result  <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                        r_inexact <= 1'b0;
                        r_invalid <= 1'b1;
                    end else if (r_zero) begin
                        r_result  <= {r_sign, {(RW-1){1'b0}}};
                        r_inexact <= 1'b0;
                    end else if (w_exp_rnd >= ExpMax) begin
                        r_result   <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_overflow <= 1'b1;
                    end else if (w_exp_rnd <= 0) begin
                        // No subnormals: flush to signed zero.
                        r_result  <= {r_sign, {(RW-1){1'b0}}};
                        r_inexact <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_man_inc[MAN_W-1:0]};
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_result;
    assign bus.out_inexact  = r_inexact;
    assign bus.out_overflow = r_overflow;
    assign bus.out_invalid  = r_invalid;
endmodule

// File: tb/tb_dec_to_ieee754_seq.sv
// Directed bench for dec_to_ieee754_seq at default parameters.
// Expected values follow DEC2FP_RNE_EN when the macro is defined, truncation otherwise.
module tb_dec_to_ieee754_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;

    dec_to_ieee754_seq_if #(.INT_W(32), .FRAC_W(32), .EXP_W(8), .MAN_W(23)) bus ();

    dec_to_ieee754_seq #(
        .INT_W(32), .FRAC_W(32), .FRAC_DIGITS(9), .EXP_W(8), .MAN_W(23), .FRAC_ITER(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one operand, then count edges after acceptance until out_valid is seen.
    // With poke set, keep in_valid high with junk operands while the converter is busy.
    task automatic convert(input logic s, input logic [31:0] i, input logic [31:0] f,
                           input bit poke, output int cycles);
        @(negedge clk);
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_int   = i;
        bus.in_frac  = f;
        @(posedge clk);
        #1;
        bus.in_valid = poke;
        bus.in_sign  = 1'b0;
        bus.in_int   = 32'h1234_5678;
        bus.in_frac  = 32'd123_456_789;
        check("in_ready_busy", bus.in_ready, 0);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            cycles++;
            #1;
            if (bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", bus.out_valid, 0);
        check("in_ready_after_hs", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_int    = '0;
        bus.in_frac   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_inexact", bus.out_inexact, 0);
        check("rst_overflow", bus.out_overflow, 0);
        check("rst_invalid", bus.out_invalid, 0);
        #21;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);

        // 1.5
        convert(1'b0, 32'd1, 32'd500_000_000, 1'b0, lat);
        check("lat_1p5", lat, 67);
        check("res_1p5", bus.out_result, 32'h3FC0_0000);
        check("inx_1p5", bus.out_inexact, 0);
        check("ovf_1p5", bus.out_overflow, 0);
        check("inv_1p5", bus.out_invalid, 0);
        handshake();

        // 0.1 with in_valid held high while busy
        convert(1'b0, 32'd0, 32'd100_000_000, 1'b1, lat);
        check("lat_0p1", lat, 67);
`ifdef DEC2FP_RNE_EN
        check("res_0p1", bus.out_result, 32'h3DCC_CCCD);
`else
        check("res_0p1", bus.out_result, 32'h3DCC_CCCC);
`endif
        check("inx_0p1", bus.out_inexact, 1);
        handshake();

        // -3.25
        convert(1'b1, 32'd3, 32'd250_000_000, 1'b0, lat);
        check("res_m3p25", bus.out_result, 32'hC050_0000);
        check("inx_m3p25", bus.out_inexact, 0);
        handshake();

        // -0
        convert(1'b1, 32'd0, 32'd0, 1'b0, lat);
        check("res_m0", bus.out_result, 32'h8000_0000);
        check("inx_m0", bus.out_inexact, 0);
        handshake();

        // Largest integer part
        convert(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, lat);
`ifdef DEC2FP_RNE_EN
        check("res_intmax", bus.out_result, 32'h4F80_0000);
`else
        check("res_intmax", bus.out_result, 32'h4F7F_FFFF);
`endif
        check("inx_intmax", bus.out_inexact, 1);
        check("ovf_intmax", bus.out_overflow, 0);
        handshake();

        // 0.999999999: rounding up carries out of the mantissa into the exponent
        convert(1'b0, 32'd0, 32'd999_999_999, 1'b0, lat);
`ifdef DEC2FP_RNE_EN
        check("res_0p999", bus.out_result, 32'h3F80_0000);
`else
        check("res_0p999", bus.out_result, 32'h3F7F_FFFF);
`endif
        check("inx_0p999", bus.out_inexact, 1);
        handshake();

        // Invalid fraction, then back-pressure for 5 cycles
        convert(1'b0, 32'd7, 32'd1_000_000_000, 1'b0, lat);
        check("lat_inv", lat, 67);
        check("res_inv", bus.out_result, 32'h7FC0_0000);
        check("inv_inv", bus.out_invalid, 1);
        check("inx_inv", bus.out_inexact, 0);
        check("ovf_inv", bus.out_overflow, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.out_result, 32'h7FC0_0000);
            check("hold_invalid", bus.out_invalid, 1);
        end
        handshake();

        // Reset in the middle of FRAC
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_int   = 32'd2;
        bus.in_frac  = 32'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_result", bus.out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(1'b0, 32'd1, 32'd500_000_000, 1'b0, lat);
        check("lat_after_rst", lat, 67);
        check("res_after_rst", bus.out_result, 32'h3FC0_0000);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
